apb_master_module: RTL and testbench

APB_MASTER_MODULE -- requirements
Module: apb_master_module

---
 rtl/apb_master_module.sv | 143 ++++++++++++++
 tb/tb_apb_master_module.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_module.sv
// APB requester: turns a valid/ready command into one SETUP/ACCESS transfer with a registered
// response. Optional ACCESS wait timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_module #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BUS_WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned STRB_W        = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
  input  logic [STRB_W-1:0]     cmd_strb_i,
  output logic                  rsp_valid_o,
  output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [STRB_W-1:0]     pstrb_o,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic [BUS_WIDTH-1:0]  prdata_i
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                state_q;
  logic                  cmd_ready_q;
  logic                  rsp_valid_q;
  logic [BUS_WIDTH-1:0]  rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  busy_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [BUS_WIDTH-1:0]  pwdata_q;
  logic [STRB_W-1:0]     pstrb_q;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_cnt_q;
`else
  // TIMEOUT_CYCLES has no effect in this build.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid_i && cmd_ready_q) begin
            state_q     <= StSetup;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            pwrite_q    <= cmd_write_i;
            paddr_q     <= cmd_addr_i;
            // Reads never expose write data or strobes on the bus.
            pwdata_q    <= cmd_write_i ? cmd_wdata_i : '0;
            pstrb_q     <= cmd_write_i ? cmd_strb_i : '0;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        StSetup: begin
          state_q   <= StAccess;
          penable_q <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        StAccess: begin
          if (pready_i) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= pslverr_i;
            rsp_rdata_q <= (!pwrite_q && !pslverr_i) ? prdata_i : '0;
`ifdef APB_MASTER_TIMEOUT_EN
          end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            tmo_cnt_q   <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = busy_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;

endmodule

// File: tb/tb_apb_master_module.sv
// Directed bench for apb_master_module: write, waited read, slave error, back-to-back,
// mid-transfer reset, and ACCESS wait behaviour (timeout when APB_MASTER_TIMEOUT_EN is defined).
module tb_apb_master_module;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [31:0] cmd_addr_i;
  logic [63:0] cmd_wdata_i;
  logic [1:0]  cmd_strb_i;
  logic        rsp_valid_o;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        busy_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] paddr_o;
  logic [63:0] pwdata_o;
  logic [1:0]  pstrb_o;
  logic        pready_i;
  logic        pslverr_i;
  logic [63:0] prdata_i;

  int n_tests = 0;
  int n_fail  = 0;

  apb_master_module #(
    .DATA_WIDTH    (32),
    .BUS_WIDTH     (64),
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i),
    .cmd_addr_i (cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i),
    .cmd_strb_i (cmd_strb_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .busy_o     (busy_o),
    .psel_o     (psel_o),
    .penable_o  (penable_o),
    .pwrite_o   (pwrite_o),
    .paddr_o    (paddr_o),
    .pwdata_o   (pwdata_o),
    .pstrb_o    (pstrb_o),
    .pready_i   (pready_i),
    .pslverr_i  (pslverr_i),
    .prdata_i   (prdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_cmd(input logic wr, input logic [31:0] a, input logic [63:0] d,
                           input logic [1:0] s);
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = a;
    cmd_wdata_i = d;
    cmd_strb_i  = s;
  endtask

  // Check the APB pins against one expected phase (psel, penable) and transfer attributes.
  task automatic check_apb(input string tag, input logic sel, input logic en, input logic wr,
                           input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
    check({tag, ".psel"}, 64'(psel_o), 64'(sel));
    check({tag, ".penable"}, 64'(penable_o), 64'(en));
    check({tag, ".pwrite"}, 64'(pwrite_o), 64'(wr));
    check({tag, ".paddr"}, 64'(paddr_o), 64'(a));
    check({tag, ".pwdata"}, pwdata_o, d);
    check({tag, ".pstrb"}, 64'(pstrb_o), 64'(s));
  endtask

  initial begin
    rst_ni      = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_write_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    cmd_strb_i  = '0;
    pready_i    = 1'b0;
    pslverr_i   = 1'b0;
    prdata_i    = '0;

    // Reset state, including cmd_ready low while held in reset.
    step();
    step();
    check("rst.cmd_ready", 64'(cmd_ready_o), 64'd0);
    check("rst.busy", 64'(busy_o), 64'd0);
    check("rst.rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst.rsp_err", 64'(rsp_err_o), 64'd0);
    check("rst.rsp_rdata", rsp_rdata_o, 64'd0);
    check_apb("rst", 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 2'b00);
    rst_ni = 1'b1;
    step();
    check("rel.cmd_ready", 64'(cmd_ready_o), 64'd1);

    // Write, zero wait states: SETUP N+1, ACCESS N+2, response N+3.
    drive_cmd(1'b1, 32'h4, 64'h1111_2222_3333_4444, 2'b11);
    pready_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    check_apb("wr.setup", 1'b1, 1'b0, 1'b1, 32'h4, 64'h1111_2222_3333_4444, 2'b11);
    check("wr.setup.busy", 64'(busy_o), 64'd1);
    check("wr.setup.cmd_ready", 64'(cmd_ready_o), 64'd0);
    step();
    check_apb("wr.access", 1'b1, 1'b1, 1'b1, 32'h4, 64'h1111_2222_3333_4444, 2'b11);
    check("wr.access.rsp_valid", 64'(rsp_valid_o), 64'd0);
    step();
    check("wr.rsp_valid", 64'(rsp_valid_o), 64'd1);
    check("wr.rsp_err", 64'(rsp_err_o), 64'd0);
    check("wr.rsp_rdata", rsp_rdata_o, 64'd0);
    check("wr.psel_done", 64'(psel_o), 64'd0);
    check("wr.busy_done", 64'(busy_o), 64'd0);
    check("wr.cmd_ready", 64'(cmd_ready_o), 64'd1);
    step();
    check("wr.rsp_pulse", 64'(rsp_valid_o), 64'd0);

    // Read with 3 wait states; pready/pslverr in SETUP must be ignored.
    drive_cmd(1'b0, 32'h8, 64'hFFFF_0000_FFFF_0000, 2'b11);
    pready_i = 1'b0;
    step();
    cmd_valid_i = 1'b0;
    pready_i    = 1'b1;
    pslverr_i   = 1'b1;
    check_apb("rd.setup", 1'b1, 1'b0, 1'b0, 32'h8, 64'h0, 2'b00);
    step();
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_apb($sformatf("rd.wait%0d", i), 1'b1, 1'b1, 1'b0, 32'h8, 64'h0, 2'b00);
      check($sformatf("rd.wait%0d.rsp_valid", i), 64'(rsp_valid_o), 64'd0);
      prdata_i = 64'h5555_5555_5555_5555;
      step();
    end
    pready_i = 1'b1;
    prdata_i = 64'hDEAD_BEEF_0000_0001;
    check_apb("rd.last", 1'b1, 1'b1, 1'b0, 32'h8, 64'h0, 2'b00);
    step();
    prdata_i = '0;
    check("rd.rsp_valid", 64'(rsp_valid_o), 64'd1);
    check("rd.rsp_rdata", rsp_rdata_o, 64'hDEAD_BEEF_0000_0001);
    check("rd.rsp_err", 64'(rsp_err_o), 64'd0);
    step();

    // Write completing with slave error.
    drive_cmd(1'b1, 32'hC, 64'hA5A5_A5A5_A5A5_A5A5, 2'b01);
    step();
    cmd_valid_i = 1'b0;
    check_apb("err.setup", 1'b1, 1'b0, 1'b1, 32'hC, 64'hA5A5_A5A5_A5A5_A5A5, 2'b01);
    step();
    pslverr_i = 1'b1;
    prdata_i  = 64'h1234_5678_9ABC_DEF0;
    step();
    pslverr_i = 1'b0;
    check("err.rsp_valid", 64'(rsp_valid_o), 64'd1);
    check("err.rsp_err", 64'(rsp_err_o), 64'd1);
    check("err.rsp_rdata", rsp_rdata_o, 64'd0);
    step();

    // Back-to-back: cmd_valid held, second accepted on the first's response cycle.
    drive_cmd(1'b1, 32'h20, 64'h0000_0000_0000_00AA, 2'b10);
    step();
    check("b2b.1.setup.psel", 64'(psel_o), 64'd1);
    check("b2b.1.setup.cmd_ready", 64'(cmd_ready_o), 64'd0);
    step();
    check("b2b.1.access.cmd_ready", 64'(cmd_ready_o), 64'd0);
    step();
    check("b2b.1.rsp_valid", 64'(rsp_valid_o), 64'd1);
    check("b2b.1.cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("b2b.gap.psel", 64'(psel_o), 64'd0);
    drive_cmd(1'b0, 32'h24, 64'h0, 2'b11);
    step();
    cmd_valid_i = 1'b0;
    check("b2b.2.rsp_valid", 64'(rsp_valid_o), 64'd0);
    check_apb("b2b.2.setup", 1'b1, 1'b0, 1'b0, 32'h24, 64'h0, 2'b00);
    step();
    prdata_i = 64'h0000_0000_CAFE_F00D;
    step();
    check("b2b.2.rsp_valid_end", 64'(rsp_valid_o), 64'd1);
    check("b2b.2.rsp_rdata", rsp_rdata_o, 64'h0000_0000_CAFE_F00D);
    step();

    // Reset during ACCESS aborts without a response; next command runs normally.
    drive_cmd(1'b1, 32'h30, 64'h77, 2'b11);
    pready_i = 1'b0;
    step();
    cmd_valid_i = 1'b0;
    step();
    check("rstmid.in_access", 64'(penable_o), 64'd1);
    rst_ni = 1'b0;
    step();
    check("rstmid.psel", 64'(psel_o), 64'd0);
    check("rstmid.busy", 64'(busy_o), 64'd0);
    check("rstmid.rsp_valid", 64'(rsp_valid_o), 64'd0);
    rst_ni   = 1'b1;
    pready_i = 1'b1;
    step();
    check("rstmid.rsp_none", 64'(rsp_valid_o), 64'd0);
    check("rstmid.cmd_ready", 64'(cmd_ready_o), 64'd1);
    drive_cmd(1'b1, 32'h34, 64'h88, 2'b01);
    step();
    cmd_valid_i = 1'b0;
    check_apb("post.setup", 1'b1, 1'b0, 1'b1, 32'h34, 64'h88, 2'b01);
    step();
    step();
    check("post.rsp_valid", 64'(rsp_valid_o), 64'd1);
    check("post.rsp_err", 64'(rsp_err_o), 64'd0);
    step();

    // ACCESS with pready held low.
    drive_cmd(1'b0, 32'h40, 64'h0, 2'b00);
    pready_i = 1'b0;
    step();
    cmd_valid_i = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wait%0d.penable", i), 64'(penable_o), 64'd1);
      check($sformatf("wait%0d.rsp_valid", i), 64'(rsp_valid_o), 64'd0);
      step();
    end
`ifdef APB_MASTER_TIMEOUT_EN
    check("tmo.rsp_valid", 64'(rsp_valid_o), 64'd1);
    check("tmo.rsp_err", 64'(rsp_err_o), 64'd1);
    check("tmo.rsp_rdata", rsp_rdata_o, 64'd0);
    check("tmo.psel", 64'(psel_o), 64'd0);
    check("tmo.busy", 64'(busy_o), 64'd0);
`else
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hold%0d.psel", i), 64'(psel_o), 64'd1);
      check($sformatf("hold%0d.rsp_valid", i), 64'(rsp_valid_o), 64'd0);
      step();
    end
    pready_i = 1'b1;
    prdata_i = 64'h0BAD_F00D_0000_0042;
    step();
    check("hold.rsp_valid", 64'(rsp_valid_o), 64'd1);
    check("hold.rsp_rdata", rsp_rdata_o, 64'h0BAD_F00D_0000_0042);
`endif
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
